// File: rtl/ld_pack_arbiter_if.sv
// ld_pack_arbiter_if: bundles the lane, packer and downstream signals of the pack arbiter.
//   slave  : arbiter view (lane_* in, lane_ready out, pk_* out, pk_out in, out_* out, err/tok_count out)
//   master : environment view (lanes, shared packer and downstream consumer), directions reversed
interface ld_pack_arbiter_if #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 2
);
    logic                    en;
    logic [NUM_LANES-1:0]    lane_valid;
    logic [NUM_LANES-1:0]    lane_ready;
    logic [NUM_LANES*12-1:0] lane_l_code;
    logic [NUM_LANES*4-1:0]  lane_l_len;
    logic [NUM_LANES*8-1:0]  lane_l_extra;
    logic [NUM_LANES*4-1:0]  lane_l_extra_len;
    logic [NUM_LANES*5-1:0]  lane_d_code;
    logic [NUM_LANES*16-1:0] lane_d_extra;
    logic [NUM_LANES*4-1:0]  lane_d_extra_len;
    logic [11:0]             pk_l_code;
    logic [3:0]              pk_l_len;
    logic [7:0]              pk_l_extra;
    logic [3:0]              pk_l_extra_len;
    logic [4:0]              pk_d_code;
    logic [15:0]             pk_d_extra;
    logic [3:0]              pk_d_extra_len;
    logic                    pk_input_valid;
    logic                    pk_enable;
    logic [31:0]             pk_out;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_data;
    logic [4:0]              out_len;
    logic [LANE_W-1:0]       out_lane;
    logic                    err;
    logic [15:0]             tok_count;
    modport slave (
        input  en, lane_valid, lane_l_code, lane_l_len, lane_l_extra, lane_l_extra_len,
               lane_d_code, lane_d_extra, lane_d_extra_len, pk_out, out_ready,
        output lane_ready, pk_l_code, pk_l_len, pk_l_extra, pk_l_extra_len, pk_d_code,
               pk_d_extra, pk_d_extra_len, pk_input_valid, pk_enable,
               out_valid, out_data, out_len, out_lane, err, tok_count
    );
    modport master (
        output en, lane_valid, lane_l_code, lane_l_len, lane_l_extra, lane_l_extra_len,
               lane_d_code, lane_d_extra, lane_d_extra_len, pk_out, out_ready,
        input  lane_ready, pk_l_code, pk_l_len, pk_l_extra, pk_l_extra_len, pk_d_code,
               pk_d_extra, pk_d_extra_len, pk_input_valid, pk_enable,
               out_valid, out_data, out_len, out_lane, err, tok_count
    );
endinterface

// File: rtl/ld_pack_arbiter.sv
// ld_pack_arbiter: round-robin share of one combinational literal/distance packer among match lanes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ld_pack_arbiter_if.slave -- lane requests/one-hot accept, packer fields/result,
//                registered valid/ready token output with length and source lane, sticky err, tok_count
module ld_pack_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 2
) (
    input logic              clk,
    input logic              rst_n,
    ld_pack_arbiter_if.slave bus
);
    logic [LANE_W-1:0] r_rr_ptr, r_out_lane, w_grant;
    logic              r_out_valid, r_err;
    logic [31:0]       r_out_data;
    logic [4:0]        r_out_len, w_len;
    logic [15:0]       r_tok_count;
    logic              w_found, w_go, w_bad_dx, w_illegal;

    // First valid lane at or after rr_ptr; index arithmetic wraps at LANE_W bits.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_LANES; k++)
            if (!w_found && bus.lane_valid[LANE_W'(r_rr_ptr + LANE_W'(k))]) begin
                w_grant = LANE_W'(r_rr_ptr + LANE_W'(k));
                w_found = 1'b1;
            end
    end

    // A new token may load in the same cycle the held one drains.
    assign w_go = bus.en & (~r_out_valid | bus.out_ready) & w_found;

    assign bus.lane_ready     = w_go ? NUM_LANES'(1) << w_grant : '0;
    assign bus.pk_l_code      = w_go ? bus.lane_l_code[w_grant*12 +: 12] : '0;
    assign bus.pk_l_len       = w_go ? bus.lane_l_len[w_grant*4 +: 4] : '0;
    assign bus.pk_l_extra     = w_go ? bus.lane_l_extra[w_grant*8 +: 8] : '0;
    assign bus.pk_l_extra_len = w_go ? bus.lane_l_extra_len[w_grant*4 +: 4] : '0;
    assign bus.pk_d_code      = w_go ? bus.lane_d_code[w_grant*5 +: 5] : '0;
    assign bus.pk_d_extra     = w_go ? bus.lane_d_extra[w_grant*16 +: 16] : '0;
    assign bus.pk_d_extra_len = w_go ? bus.lane_d_extra_len[w_grant*4 +: 4] : '0;
    assign bus.pk_input_valid = w_go;
    assign bus.pk_enable      = 1'b1;

    // Match token: 7-bit length code + extra, 5-bit distance code + extra.
    assign w_bad_dx  = |bus.pk_d_code & (bus.pk_d_extra_len > 4'd13);
    assign w_illegal = w_bad_dx | (|bus.pk_d_code & (bus.pk_l_extra_len > 4'd3));
    assign w_len     = ~|bus.pk_d_code ? (bus.pk_l_len == 4'd8 ? 5'd8 : 5'd9) :
                       w_illegal ? 5'd0 : 5'd12 + {1'b0, bus.pk_l_extra_len} + {1'b0, bus.pk_d_extra_len};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_len   <= '0;
            r_out_lane  <= '0;
            r_err       <= 1'b0;
            r_tok_count <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_tok_count <= r_tok_count + 16'(r_out_valid & bus.out_ready);
            if (w_go) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_bad_dx ? '0 : bus.pk_out;
                r_out_len   <= w_len;
                r_out_lane  <= w_grant;
                r_rr_ptr    <= w_grant + LANE_W'(1);
                if (w_illegal) r_err <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_len   = r_out_len;
    assign bus.out_lane  = r_out_lane;
    assign bus.err       = r_err;
    assign bus.tok_count = r_tok_count;
endmodule

// File: tb/tb_ld_pack_arbiter.sv
// tb_ld_pack_arbiter: directed vectors and corner sequences for ld_pack_arbiter with a packer model.
module tb_ld_pack_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ld_pack_arbiter_if #(.NUM_LANES(4), .LANE_W(2)) bus ();
    ld_pack_arbiter #(.NUM_LANES(4), .LANE_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Shared packer: literal = code masked to l_len; match = {l_code[6:0], l_extra, d_code, d_extra} right-aligned.
    function automatic logic [31:0] pack(input logic [11:0] lc, input logic [3:0] ll, input logic [7:0] lx,
                                         input logic [3:0] lxl, input logic [4:0] dc, input logic [15:0] dx,
                                         input logic [3:0] dxl);
        logic [31:0] v;
        if (dc == 5'd0) return {20'b0, lc} & ((32'd1 << ll) - 32'd1);
        if (dxl > 4'd13) return 32'd0;
        v = {25'b0, lc[6:0]};
        v = (v << lxl) | {24'b0, lx};
        v = (v << 5) | {27'b0, dc};
        v = (v << dxl) | {16'b0, dx};
        return v;
    endfunction

    always_comb bus.pk_out = pack(bus.pk_l_code, bus.pk_l_len, bus.pk_l_extra, bus.pk_l_extra_len,
                                  bus.pk_d_code, bus.pk_d_extra, bus.pk_d_extra_len);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [11:0] lc, input logic [3:0] ll, input logic [7:0] lx,
                            input logic [3:0] lxl, input logic [4:0] dc, input logic [15:0] dx,
                            input logic [3:0] dxl);
        bus.lane_valid[i] = 1'b1;
        bus.lane_l_code[i*12 +: 12] = lc;
        bus.lane_l_len[i*4 +: 4] = ll;
        bus.lane_l_extra[i*8 +: 8] = lx;
        bus.lane_l_extra_len[i*4 +: 4] = lxl;
        bus.lane_d_code[i*5 +: 5] = dc;
        bus.lane_d_extra[i*16 +: 16] = dx;
        bus.lane_d_extra_len[i*4 +: 4] = dxl;
    endtask

    typedef struct {
        int          lane;
        logic [11:0] lc;
        logic [3:0]  ll;
        logic [7:0]  lx;
        logic [3:0]  lxl;
        logic [4:0]  dc;
        logic [15:0] dx;
        logic [3:0]  dxl;
        logic [31:0] ed;
        logic [4:0]  el;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 12'h0A5, 4'd8, 8'h00, 4'd0, 5'd0,  16'h0000, 4'd0,  32'h000000A5, 5'd8};
        vecs[1] = '{2, 12'h015, 4'd0, 8'h01, 4'd2, 5'd3,  16'h0000, 4'd0,  32'h00000AA3, 5'd14};
        vecs[2] = '{1, 12'h1F3, 4'd9, 8'h00, 4'd0, 5'd0,  16'h0000, 4'd0,  32'h000001F3, 5'd9};
        vecs[3] = '{3, 12'h07F, 4'd0, 8'h00, 4'd0, 5'h1D, 16'h1ABC, 4'd13, 32'h01FFBABC, 5'd25};
        vecs[4] = '{0, 12'h001, 4'd0, 8'h05, 4'd3, 5'd2,  16'h0001, 4'd13, 32'h00344001, 5'd28};
        bus.en = 1'b1;
        bus.out_ready = 1'b1;
        bus.lane_valid = '0;
        bus.lane_l_code = '0;
        bus.lane_l_len = '0;
        bus.lane_l_extra = '0;
        bus.lane_l_extra_len = '0;
        bus.lane_d_code = '0;
        bus.lane_d_extra = '0;
        bus.lane_d_extra_len = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_len", 32'(bus.out_len), 32'd0);
        chk("rst_out_lane", 32'(bus.out_lane), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_tok_count", 32'(bus.tok_count), 32'd0);
        chk("rst_lane_ready", 32'(bus.lane_ready), 32'd0);
        // Table: one lane valid at a time, so it is granted whatever rr_ptr holds.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.lane_valid = '0;
            set_lane(vecs[i].lane, vecs[i].lc, vecs[i].ll, vecs[i].lx, vecs[i].lxl, vecs[i].dc, vecs[i].dx, vecs[i].dxl);
            #1 chk("vec_lane_ready", 32'(bus.lane_ready), 32'd1 << vecs[i].lane);
            @(negedge clk);
            bus.lane_valid = '0;
            chk("vec_out_valid", 32'(bus.out_valid), 32'd1);
            chk("vec_out_data", bus.out_data, vecs[i].ed);
            chk("vec_out_len", 32'(bus.out_len), 32'(vecs[i].el));
            chk("vec_out_lane", 32'(bus.out_lane), 32'(vecs[i].lane));
        end
        @(negedge clk);
        chk("vec_tok_count", 32'(bus.tok_count), 32'd5);
        chk("vec_drained", 32'(bus.out_valid), 32'd0);
        // Round robin from a fresh rr_ptr of 0.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_lane(i, 12'h010 + 12'(i), 4'd8, 8'h00, 4'd0, 5'd0, 16'h0000, 4'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_out_valid", 32'(bus.out_valid), 32'd1);
            chk("rr_out_lane", 32'(bus.out_lane), 32'(k % 4));
            chk("rr_out_data", bus.out_data, 32'h10 + 32'(k % 4));
        end
        bus.lane_valid = '0;
        @(negedge clk);
        chk("rr_tok_count", 32'(bus.tok_count), 32'd5);
        // Backpressure: rr_ptr is 1, lanes 1 and 3 compete.
        bus.out_ready = 1'b0;
        set_lane(1, 12'h021, 4'd8, 8'h00, 4'd0, 5'd0, 16'h0000, 4'd0);
        set_lane(3, 12'h023, 4'd8, 8'h00, 4'd0, 5'd0, 16'h0000, 4'd0);
        #1 chk("bp_first_ready", 32'(bus.lane_ready), 32'b0010);
        @(negedge clk);
        chk("bp_load_lane", 32'(bus.out_lane), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_ready", 32'(bus.lane_ready), 32'd0);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_lane", 32'(bus.out_lane), 32'd1);
            chk("bp_hold_data", bus.out_data, 32'h21);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(bus.lane_ready), 32'b1000);
        @(negedge clk);
        chk("bp_next_lane", 32'(bus.out_lane), 32'd3);
        chk("bp_next_data", bus.out_data, 32'h23);
        chk("bp_tok_count", 32'(bus.tok_count), 32'd6);
        bus.lane_valid = '0;
        @(negedge clk);
        chk("bp_tok_drained", 32'(bus.tok_count), 32'd7);
        // Illegal fields, then a legal token: err stays set.
        set_lane(2, 12'h011, 4'd0, 8'h00, 4'd0, 5'd4, 16'hFFFF, 4'd14);
        @(negedge clk);
        bus.lane_valid = '0;
        chk("ill_dx_lane", 32'(bus.out_lane), 32'd2);
        chk("ill_dx_len", 32'(bus.out_len), 32'd0);
        chk("ill_dx_data", bus.out_data, 32'd0);
        chk("ill_dx_err", 32'(bus.err), 32'd1);
        set_lane(1, 12'h001, 4'd0, 8'h0F, 4'd4, 5'd1, 16'h0000, 4'd0);
        @(negedge clk);
        bus.lane_valid = '0;
        chk("ill_lx_data", bus.out_data, 32'h3E1);
        chk("ill_lx_len", 32'(bus.out_len), 32'd0);
        set_lane(0, 12'h05A, 4'd8, 8'h00, 4'd0, 5'd0, 16'h0000, 4'd0);
        @(negedge clk);
        bus.lane_valid = '0;
        chk("ill_after_data", bus.out_data, 32'h5A);
        chk("ill_after_len", 32'(bus.out_len), 32'd8);
        chk("ill_err_sticky", 32'(bus.err), 32'd1);
        @(negedge clk);
        // Enable low: no grants, rr_ptr frozen at 1, held token drains.
        bus.out_ready = 1'b0;
        set_lane(0, 12'h033, 4'd8, 8'h00, 4'd0, 5'd0, 16'h0000, 4'd0);
        @(negedge clk);
        chk("en_held_lane", 32'(bus.out_lane), 32'd0);
        bus.en = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) set_lane(i, 12'h040 + 12'(i), 4'd8, 8'h00, 4'd0, 5'd0, 16'h0000, 4'd0);
        #1 chk("en_low_ready", 32'(bus.lane_ready), 32'd0);
        @(negedge clk);
        chk("en_low_drained", 32'(bus.out_valid), 32'd0);
        chk("en_low_ready2", 32'(bus.lane_ready), 32'd0);
        bus.en = 1'b1;
        #1 chk("en_rr_frozen", 32'(bus.lane_ready), 32'b0010);
        @(negedge clk);
        chk("en_resume_valid", 32'(bus.out_valid), 32'd1);
        chk("en_resume_lane", 32'(bus.out_lane), 32'd1);
        // Asynchronous reset while a token is held.
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_tok_count", 32'(bus.tok_count), 32'd0);
        chk("arst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
